video_timing_decoder: RTL and testbench

- Receive-side counterpart of pixel_iterator.
- Samples an hs/vs/de stream and recovers per-pixel x/y coordinates.
- Measures the line and frame geometry of the stream and asserts locked once that geometry is stable.
- Used for loopback self-check of the pixel_iterator → dvi_tx path and as the front end of later capture/overlay blocks.

---
 rtl/video_timing_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_video_timing_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_decoder.sv
// Recovers pixel coordinates from an hs/vs/de stream and measures line/frame geometry.
// Lock is declared after LOCK_FRAMES consecutive identical frame measurements.
module video_timing_decoder #(
    parameter int HOR_TOTAL_PIXELS  = 1650,
    parameter int HOR_ACTIVE_PIXELS = 1280,
    parameter int VER_TOTAL_PIXELS  = 750,
    parameter int VER_ACTIVE_PIXELS = 720,
    parameter int SYNC_ACTIVE_HIGH  = 1,
    parameter int LOCK_FRAMES       = 2,
    localparam int X_WIDTH  = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH  = $clog2(VER_ACTIVE_PIXELS),
    localparam int HT_WIDTH = $clog2(HOR_TOTAL_PIXELS + 1),
    localparam int VT_WIDTH = $clog2(VER_TOTAL_PIXELS + 1)
) (
    input  logic                clk_rgb,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                hs,
    input  logic                vs,
    input  logic                de,
    output logic [X_WIDTH-1:0]  x,
    output logic [Y_WIDTH-1:0]  y,
    output logic                pixel_valid,
    output logic                frame_start,
    output logic [HT_WIDTH-1:0] h_total,
    output logic [HT_WIDTH-1:0] h_active,
    output logic [VT_WIDTH-1:0] v_total,
    output logic [VT_WIDTH-1:0] v_active,
    output logic                locked,
    output logic                mode_match
);
    localparam int HC_WIDTH = $clog2(2 * HOR_TOTAL_PIXELS + 2);
    localparam int VC_WIDTH = $clog2(2 * VER_TOTAL_PIXELS + 1);
    localparam int MC_WIDTH = $clog2(LOCK_FRAMES + 1);
    localparam logic [HC_WIDTH-1:0] H_LIMIT = HC_WIDTH'(2 * HOR_TOTAL_PIXELS);
    localparam logic [VC_WIDTH-1:0] V_LIMIT = VC_WIDTH'(2 * VER_TOTAL_PIXELS);
    localparam logic [HC_WIDTH-1:0] X_MAX   = HC_WIDTH'((1 << X_WIDTH) - 1);
    localparam logic [HC_WIDTH-1:0] HT_MAX  = HC_WIDTH'((1 << HT_WIDTH) - 1);
    localparam logic [VC_WIDTH-1:0] VT_MAX  = VC_WIDTH'((1 << VT_WIDTH) - 1);
    localparam logic [Y_WIDTH-1:0]  Y_MAX   = '1;
    localparam logic [MC_WIDTH-1:0] LOCK_C  = MC_WIDTH'(LOCK_FRAMES);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN} state_t;

    state_t state_reg, state_next;
    logic [MC_WIDTH-1:0] match_cnt_reg, match_cnt_next;
    logic publish;

    logic hs_s1_reg, hs_s2_reg, vs_s1_reg, vs_s2_reg, de_s1_reg, de_s2_reg;
    logic [HC_WIDTH-1:0] h_cnt_reg, de_cnt_reg, line_len_reg, line_act_reg;
    logic [HC_WIDTH-1:0] first_len_reg, first_act_reg;
    logic [VC_WIDTH-1:0] v_cnt_reg;
    logic len_seen_reg, act_seen_reg, line_err_reg;

    logic hs_pol, vs_pol;
    logic hs_rise, vs_rise, de_fall, h_timeout, v_timeout, timeout, same_geom;
    logic [HC_WIDTH-1:0] h_cnt_inc, len_now, act_now;
    logic [HT_WIDTH-1:0] snap_h_total, snap_h_active;
    logic [VT_WIDTH-1:0] snap_v_total, snap_v_active;

    assign hs_pol  = (SYNC_ACTIVE_HIGH != 0) ? hs : ~hs;
    assign vs_pol  = (SYNC_ACTIVE_HIGH != 0) ? vs : ~vs;
    assign hs_rise = hs_s1_reg & ~hs_s2_reg;
    assign vs_rise = vs_s1_reg & ~vs_s2_reg;
    assign de_fall = ~de_s1_reg & de_s2_reg;

    // A sync edge arriving in the same cycle as the saturated count is not a timeout.
    assign h_timeout = (h_cnt_reg == H_LIMIT) && !hs_rise;
    assign v_timeout = (v_cnt_reg == V_LIMIT) && !vs_rise;
    assign timeout   = h_timeout || v_timeout;

    // Snapshot sees a line or active run that ends in the vs-rise cycle itself.
    assign h_cnt_inc = h_cnt_reg + 1'b1;
    assign len_now   = hs_rise ? h_cnt_inc : line_len_reg;
    assign act_now   = de_fall ? de_cnt_reg : line_act_reg;

    assign snap_h_total  = (len_now > HT_MAX) ? '1 : len_now[HT_WIDTH-1:0];
    assign snap_h_active = (act_now > HT_MAX) ? '1 : act_now[HT_WIDTH-1:0];
    assign snap_v_total  = (v_cnt_reg > VT_MAX) ? '1 : v_cnt_reg[VT_WIDTH-1:0];
    assign snap_v_active = VT_WIDTH'(y) + VT_WIDTH'(de_fall);

    assign same_geom = (snap_h_total == h_total) && (snap_h_active == h_active) &&
                       (snap_v_total == v_total) && (snap_v_active == v_active);

    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        publish        = 1'b0;
        if (timeout) begin
            state_next     = ST_IDLE;
            match_cnt_next = '0;
        end else if (vs_rise) begin
            case (state_reg)
                ST_IDLE:  state_next = ST_ARMED;
                ST_ARMED: begin
                    state_next = ST_RUN;
                    publish    = 1'b1;
                end
                ST_RUN: begin
                    publish = 1'b1;
                    if (same_geom && !line_err_reg)
                        match_cnt_next = (match_cnt_reg == LOCK_C) ? match_cnt_reg : match_cnt_reg + 1'b1;
                    else
                        match_cnt_next = '0;
                end
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_rgb or negedge rst_n) begin
        if (!rst_n) begin
            {hs_s1_reg, hs_s2_reg, vs_s1_reg, vs_s2_reg, de_s1_reg, de_s2_reg} <= '0;
            h_cnt_reg     <= '0;
            de_cnt_reg    <= '0;
            line_len_reg  <= '0;
            line_act_reg  <= '0;
            first_len_reg <= '0;
            first_act_reg <= '0;
            v_cnt_reg     <= '0;
            len_seen_reg  <= 1'b0;
            act_seen_reg  <= 1'b0;
            line_err_reg  <= 1'b0;
            state_reg     <= ST_IDLE;
            match_cnt_reg <= '0;
            x             <= '0;
            y             <= '0;
            pixel_valid   <= 1'b0;
            frame_start   <= 1'b0;
            h_total       <= '0;
            h_active      <= '0;
            v_total       <= '0;
            v_active      <= '0;
        end else if (ce) begin
            hs_s1_reg <= hs_pol;
            vs_s1_reg <= vs_pol;
            de_s1_reg <= de;
            hs_s2_reg <= hs_s1_reg;
            vs_s2_reg <= vs_s1_reg;
            de_s2_reg <= de_s1_reg;

            if (hs_rise) begin
                h_cnt_reg    <= '0;
                line_len_reg <= h_cnt_inc;
            end else if (h_cnt_reg != H_LIMIT) begin
                h_cnt_reg <= h_cnt_inc;
            end

            if (hs_rise)
                de_cnt_reg <= '0;
            else if (de_s1_reg && de_cnt_reg != H_LIMIT)
                de_cnt_reg <= de_cnt_reg + 1'b1;
            if (de_fall)
                line_act_reg <= de_cnt_reg;

            pixel_valid <= de_s1_reg;
            if (de_s1_reg)
                x <= (de_cnt_reg > X_MAX) ? '1 : de_cnt_reg[X_WIDTH-1:0];

            if (vs_rise)
                y <= '0;
            else if (de_fall && y != Y_MAX)
                y <= y + 1'b1;

            if (vs_rise)
                v_cnt_reg <= VC_WIDTH'(hs_rise);
            else if (hs_rise && v_cnt_reg != V_LIMIT)
                v_cnt_reg <= v_cnt_reg + 1'b1;

            // The line closing in the vs-rise cycle belongs to neither frame's consistency check.
            if (vs_rise) begin
                line_err_reg <= 1'b0;
                len_seen_reg <= 1'b0;
                act_seen_reg <= 1'b0;
            end else begin
                if (hs_rise) begin
                    if (!len_seen_reg) begin
                        first_len_reg <= h_cnt_inc;
                        len_seen_reg  <= 1'b1;
                    end else if (h_cnt_inc != first_len_reg) begin
                        line_err_reg <= 1'b1;
                    end
                end
                if (de_fall) begin
                    if (!act_seen_reg) begin
                        first_act_reg <= de_cnt_reg;
                        act_seen_reg  <= 1'b1;
                    end else if (de_cnt_reg != first_act_reg) begin
                        line_err_reg <= 1'b1;
                    end
                end
            end

            frame_start   <= vs_rise;
            state_reg     <= state_next;
            match_cnt_reg <= match_cnt_next;
            if (publish) begin
                h_total  <= snap_h_total;
                h_active <= snap_h_active;
                v_total  <= snap_v_total;
                v_active <= snap_v_active;
            end
        end
    end

    assign locked     = (match_cnt_reg == LOCK_C);
    assign mode_match = locked &&
                        (h_total  == HT_WIDTH'(HOR_TOTAL_PIXELS))  &&
                        (h_active == HT_WIDTH'(HOR_ACTIVE_PIXELS)) &&
                        (v_total  == VT_WIDTH'(VER_TOTAL_PIXELS))  &&
                        (v_active == VT_WIDTH'(VER_ACTIVE_PIXELS));
endmodule

// File: tb/tb_video_timing_decoder.sv
// Directed bench for video_timing_decoder on a reduced raster (40x13 total, 30x9 active).
module tb_video_timing_decoder;
    localparam int HT = 40, HA = 30, VT = 13, VA = 9, LF = 2;
    localparam int FRAME = HT * VT;
    localparam int HS_W = 4, DE_H0 = 6, DE_V0 = 2;

    logic clk_rgb = 1'b0, rst_n = 1'b1, ce = 1'b1, hs = 1'b0, vs = 1'b0, de = 1'b0;
    logic [4:0] x;
    logic [3:0] y;
    logic pixel_valid, frame_start, locked, mode_match;
    logic [5:0] h_total, h_active;
    logic [3:0] v_total, v_active;

    int n_cmp = 0, n_bad = 0;
    int gh = 0, gv = 0, long_v = -1;
    bit hold_gen = 1'b0;

    video_timing_decoder #(
        .HOR_TOTAL_PIXELS(HT), .HOR_ACTIVE_PIXELS(HA),
        .VER_TOTAL_PIXELS(VT), .VER_ACTIVE_PIXELS(VA),
        .SYNC_ACTIVE_HIGH(1), .LOCK_FRAMES(LF)
    ) dut (
        .clk_rgb(clk_rgb), .rst_n(rst_n), .ce(ce), .hs(hs), .vs(vs), .de(de),
        .x(x), .y(y), .pixel_valid(pixel_valid), .frame_start(frame_start),
        .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
        .locked(locked), .mode_match(mode_match)
    );

    always #5 clk_rgb = ~clk_rgb;

    // Apply the current raster pixel for one clock, then advance the raster position.
    task automatic tick();
        if (hold_gen) begin
            hs = 1'b0; vs = 1'b0; de = 1'b0;
        end else begin
            hs = (gh < HS_W);
            vs = (gv == 0);
            de = (gv >= DE_V0 && gv < DE_V0 + VA && gh >= DE_H0 && gh < DE_H0 + HA);
        end
        @(posedge clk_rgb); #1;
        if (!hold_gen) begin
            if (gh == ((gv == long_v) ? HT : HT - 1)) begin
                gh = 0;
                gv = (gv == VT - 1) ? 0 : gv + 1;
            end else begin
                gh++;
            end
        end
    endtask

    task automatic run_to(input int tv, input int th);
        int i = 0;
        do begin
            tick();
            i++;
        end while (!(gv == tv && gh == th) && i < 4 * FRAME);
        n_cmp++;
        if (!(gv == tv && gh == th)) begin
            n_bad++;
            $display("FAIL run_to: reached v=%0d h=%0d, required v=%0d h=%0d", gv, gh, tv, th);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            hs = 1'($urandom); vs = 1'($urandom); de = 1'($urandom);
            @(posedge clk_rgb); #1;
            n_cmp++;
            if ({x, y, pixel_valid, frame_start, h_total, h_active, v_total, v_active, locked, mode_match} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: cycle %0d outputs not zero (h_total=%0d x=%0d locked=%0b)", i, h_total, x, locked);
            end
        end
        rst_n = 1'b1;
        gh = 0; gv = 0;
    endtask

    task automatic test_lock();
        repeat (FRAME + 1) tick();
        n_cmp++;
        if (h_total !== 6'd0) begin n_bad++; $display("FAIL pre_publish_h_total: got %0d want 0", h_total); end
        tick();
        n_cmp++;
        if (h_total !== 6'(HT)) begin n_bad++; $display("FAIL first_h_total: got %0d want %0d", h_total, HT); end
        n_cmp++;
        if (h_active !== 6'(HA)) begin n_bad++; $display("FAIL first_h_active: got %0d want %0d", h_active, HA); end
        n_cmp++;
        if (v_total !== 4'(VT)) begin n_bad++; $display("FAIL first_v_total: got %0d want %0d", v_total, VT); end
        n_cmp++;
        if (v_active !== 4'(VA)) begin n_bad++; $display("FAIL first_v_active: got %0d want %0d", v_active, VA); end
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL early_locked: got %0b want 0", locked); end
        repeat (2 * FRAME - 1) tick();
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL locked_before_4th: got %0b want 0", locked); end
        tick();
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL locked_after_4th: got %0b want 1", locked); end
        n_cmp++;
        if (mode_match !== 1'b1) begin n_bad++; $display("FAIL mode_match: got %0b want 1", mode_match); end
    endtask

    task automatic test_pixels();
        run_to(DE_V0, DE_H0);
        tick();
        n_cmp++;
        if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL pv_latency1: got %0b want 0", pixel_valid); end
        tick();
        n_cmp++;
        if ({pixel_valid, x, y} !== {1'b1, 5'd0, 4'd0}) begin
            n_bad++; $display("FAIL first_pixel: got pv=%0b x=%0d y=%0d want pv=1 x=0 y=0", pixel_valid, x, y);
        end
        run_to(DE_V0 + VA - 1, DE_H0 + HA - 1);
        tick(); tick();
        n_cmp++;
        if ({pixel_valid, x, y} !== {1'b1, 5'(HA - 1), 4'(VA - 1)}) begin
            n_bad++; $display("FAIL last_pixel: got pv=%0b x=%0d y=%0d want pv=1 x=%0d y=%0d", pixel_valid, x, y, HA - 1, VA - 1);
        end
        tick();
        n_cmp++;
        if ({pixel_valid, y} !== {1'b0, 4'(VA)}) begin
            n_bad++; $display("FAIL after_last: got pv=%0b y=%0d want pv=0 y=%0d", pixel_valid, y, VA);
        end
        run_to(0, 0);
        tick(); tick();
        n_cmp++;
        if (frame_start !== 1'b1) begin n_bad++; $display("FAIL frame_start_pulse: got %0b want 1", frame_start); end
        tick();
        n_cmp++;
        if (frame_start !== 1'b0) begin n_bad++; $display("FAIL frame_start_end: got %0b want 0", frame_start); end
    endtask

    task automatic test_long_line();
        run_to(0, 0);
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL locked_before_long: got %0b want 1", locked); end
        long_v = 5;
        run_to(0, 0);
        long_v = -1;
        tick(); tick();
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL long_line_unlock: got %0b want 0", locked); end
        n_cmp++;
        if (h_total !== 6'(HT)) begin n_bad++; $display("FAIL long_line_h_total: got %0d want %0d", h_total, HT); end
        run_to(0, 0); tick(); tick();
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL relock_one_frame: got %0b want 0", locked); end
        run_to(0, 0); tick(); tick();
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL relock_two_frames: got %0b want 1", locked); end
    endtask

    task automatic test_timeout();
        run_to(3, 5);
        hold_gen = 1'b1;
        repeat (70) tick();
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL timeout_early: got %0b want 1", locked); end
        repeat (20) tick();
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL timeout_unlock: got %0b want 0", locked); end
        n_cmp++;
        if ({h_total, v_total} !== {6'(HT), 4'(VT)}) begin
            n_bad++; $display("FAIL timeout_hold_meas: got h_total=%0d v_total=%0d want %0d %0d", h_total, v_total, HT, VT);
        end
        hold_gen = 1'b0; gh = 0; gv = 0;
        repeat (2 * FRAME + 2) tick();
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL timeout_relock_3rd: got %0b want 0", locked); end
        repeat (FRAME) tick();
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL timeout_relock_4th: got %0b want 1", locked); end
    endtask

    task automatic test_ce();
        run_to(4, 15);
        tick(); tick();
        n_cmp++;
        if ({pixel_valid, x, y} !== {1'b1, 5'd9, 4'd2}) begin
            n_bad++; $display("FAIL ce_before: got pv=%0b x=%0d y=%0d want pv=1 x=9 y=2", pixel_valid, x, y);
        end
        ce = 1'b0;
        for (int i = 0; i < 100; i++) begin
            hs = 1'($urandom); vs = 1'($urandom); de = 1'($urandom);
            @(posedge clk_rgb); #1;
        end
        n_cmp++;
        if ({pixel_valid, x, y, h_total, locked} !== {1'b1, 5'd9, 4'd2, 6'(HT), 1'b1}) begin
            n_bad++; $display("FAIL ce_frozen: got pv=%0b x=%0d y=%0d h_total=%0d locked=%0b", pixel_valid, x, y, h_total, locked);
        end
        ce = 1'b1;
        tick();
        n_cmp++;
        if (x !== 5'd10) begin n_bad++; $display("FAIL ce_resume_x1: got %0d want 10", x); end
        tick();
        n_cmp++;
        if (x !== 5'd11) begin n_bad++; $display("FAIL ce_resume_x2: got %0d want 11", x); end
    endtask

    task automatic test_midframe_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({h_total, v_active, locked, pixel_valid, x} !== '0) begin
            n_bad++; $display("FAIL async_reset: got h_total=%0d v_active=%0d locked=%0b pv=%0b x=%0d want all 0", h_total, v_active, locked, pixel_valid, x);
        end
        @(posedge clk_rgb); #1;
        rst_n = 1'b1;
        run_to(0, 0); tick(); tick();
        n_cmp++;
        if ({frame_start, h_total} !== {1'b1, 6'd0}) begin
            n_bad++; $display("FAIL rearm_only: got frame_start=%0b h_total=%0d want 1 0", frame_start, h_total);
        end
        repeat (FRAME) tick();
        n_cmp++;
        if ({h_total, v_active, locked} !== {6'(HT), 4'(VA), 1'b0}) begin
            n_bad++; $display("FAIL post_reset_publish: got h_total=%0d v_active=%0d locked=%0b want %0d %0d 0", h_total, v_active, locked, HT, VA);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixels();
        test_long_line();
        test_timeout();
        test_ce();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
